alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter M, default 4, meaning ALU instruction width; bit M-1 selects the logic or arithmetic unit.
REQ-003 The block SHALL have parameter LAT, default 1, meaning ALU result latency in clk cycles (LAT >= 1).
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-007 req_ready  output  2  per-requester accept strobe.
REQ-008 req_a0, req_b0, req_a1, req_b1  input  N each  requester operands.
REQ-009 req_instr0, req_instr1  input  M each  requester instruction.
REQ-010 rsp_valid  output  2  per-requester result valid.
REQ-011 rsp_ready  input  2  per-requester result accept.
REQ-012 rsp_data  output  N  result; valid only with the asserted rsp_valid bit.
REQ-013 alu_a, alu_b  output  N each  operands to the shared ALU.
REQ-014 alu_instr  output  M  instruction to the shared ALU.
REQ-015 alu_result  input  N  shared ALU output.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-018 In IDLE, the grant SHALL go to the single valid requester; when both are valid, it SHALL go to the requester not served last.
REQ-019 req_ready[i] SHALL equal (state==IDLE && grant==i); at most one bit SHALL be high.
REQ-020 On the req_valid[i] && req_ready[i] edge, the block SHALL latch the operands, instruction and id i, load the cycle counter with LAT-1, and enter EXEC.
REQ-021 alu_a, alu_b and alu_instr SHALL be driven from the latched registers, passed through unmodified, and held constant from acceptance until the next acceptance.
REQ-022 In EXEC, the counter SHALL decrement each cycle; at count 0 the block SHALL capture alu_result into rsp_data and enter RESP.
REQ-023 In RESP, rsp_valid[id] SHALL be high; rsp_data and rsp_valid SHALL remain stable until rsp_ready[id] is high, after which the state SHALL be IDLE on the next cycle.
REQ-024 Latency: the accept edge at cycle t SHALL produce rsp_valid at cycle t+LAT+1; peak throughput SHALL be one operation per LAT+2 cycles.
REQ-025 rsp_ready bits for the non-active requester, and rsp_ready asserted outside RESP, SHALL be ignored.
REQ-026 A requester deasserting req_valid before being accepted SHALL have no effect.
REQ-027 The last-served pointer SHALL update only on acceptance.

Reset
REQ-028 While rst_n is low, the state SHALL be IDLE and the last-served pointer SHALL be 1, so that requester 0 wins the first tie.
REQ-029 While rst_n is low, rsp_valid, rsp_data, alu_a, alu_b, alu_instr and busy SHALL be 0, and the counter SHALL be 0.
REQ-030 A reset asserted mid-EXEC or mid-RESP SHALL abandon the operation with no response issued.

Structure
REQ-031 Package alu_pkg SHALL hold the FSM state enum and the default N and M constants.
REQ-032 The two-way round-robin picker SHALL be a sub-module rr_arb2 (inputs: valid[1:0], last; output: grant).

Verification
REQ-033 Single op: req0 with a=3, b=5, instr=4'b0001, and the ALU model returning 8 -> alu_instr=4'b0001, rsp_valid=2'b01 two cycles after accept (LAT=1), rsp_data=8.
REQ-034 Tie after reset: both requesters valid -> requester 0 is served first, then requester 1; both valid again -> requester 0 is served.
REQ-035 Backpressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data are stable, req_ready=2'b00, and busy=1.
REQ-036 Reset mid-EXEC: rst_n is pulled low -> outputs are 0 immediately and no rsp_valid follows; the next tie goes to requester 0.
REQ-037 LAT=3: accept at cycle t -> rsp_valid rises at t+4; alu_result sampled at t+3 is returned even if alu_result changes afterwards.
REQ-038 A wrong-requester rsp_ready[1] pulse while serving requester 0 -> no state change.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU arbiter slice.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int N_DEF = 4;
  localparam int M_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant
);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = ~last;
    if (valid == 2'b01) begin
      grant = 1'b0;
    end else if (valid == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: arbitrate, launch, wait LAT cycles,
// then hold the result until the owning requester takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int M   = M_DEF,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [M-1:0] req_instr0,
  input  logic [M-1:0] req_instr1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [M-1:0] alu_instr,
  input  logic [N-1:0] alu_result,
  output logic         busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           id_q, id_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [M-1:0]   instr_q, instr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   data_q, data_d;
  logic           grant;

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    req_ready = 2'b00;

    case (state_q)
      IDLE: begin
        req_ready = grant ? 2'b10 : 2'b01;
        if (req_valid[grant]) begin
          id_d    = grant;
          last_d  = grant;
          a_d     = grant ? req_a1 : req_a0;
          b_d     = grant ? req_b1 : req_b0;
          instr_d = grant ? req_instr1 : req_instr0;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // The ALU has had LAT cycles with stable operands once the count reaches zero.
        if (cnt_q == '0) begin
          data_d  = alu_result;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = data_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_instr = instr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter (LAT=1) plus a directed LAT=3 instance.
module tb_alu_arbiter;

  localparam int N   = 4;
  localparam int M   = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0] req_a0, req_b0, req_a1, req_b1, rsp_data, alu_a, alu_b, alu_result;
  logic [M-1:0] req_instr0, req_instr1, alu_instr;
  logic         busy;

  logic [1:0]   req_valid_3, req_ready_3, rsp_valid_3, rsp_ready_3;
  logic [N-1:0] req_a0_3, req_b0_3, req_a1_3, req_b1_3, rsp_data_3, alu_a_3, alu_b_3, alu_result_3;
  logic [M-1:0] req_instr0_3, req_instr1_3, alu_instr_3;
  logic         busy_3;

  alu_arbiter #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_instr0(req_instr0), .req_instr1(req_instr1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr),
    .alu_result(alu_result), .busy(busy)
  );

  alu_arbiter #(.N(N), .M(M), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_a0(req_a0_3), .req_b0(req_b0_3), .req_a1(req_a1_3), .req_b1(req_b1_3),
    .req_instr0(req_instr0_3), .req_instr1(req_instr1_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_data(rsp_data_3),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_instr(alu_instr_3),
    .alu_result(alu_result_3), .busy(busy_3)
  );

  // Environment ALU: instr 4'b0001 is an add; bit M-1 selects subtract, bit 2 inverts.
  function automatic logic [N-1:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [M-1:0] instr);
    logic [N-1:0] r;
    case (instr[1:0])
      2'd0:    r = a & b;
      2'd1:    r = a + b;
      2'd2:    r = a ^ b;
      default: r = a | b;
    endcase
    if (instr[M-1]) r = a - b;
    if (instr[2])   r = ~r;
    return r;
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_instr);

  typedef struct {
    logic         id;
    logic [N-1:0] data;
    int           start;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: whether the arbiter is free, who was served last,
  // and what the ALU ports should be holding.
  logic         m_last;
  logic         m_pending;
  logic         m_id;
  int           m_resp_start;
  int           m_idle_from;
  logic [N-1:0] m_a, m_b;
  logic [M-1:0] m_i;

  task automatic model_reset();
    m_last      = 1'b1;
    m_pending   = 1'b0;
    m_id        = 1'b0;
    m_idle_from = 0;
    m_a = '0; m_b = '0; m_i = '0;
    sb_q.delete();
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [N-1:0] a0, input logic [N-1:0] b0, input logic [M-1:0] i0,
                       input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [M-1:0] i1,
                       input logic [1:0] rr);
    logic       idle, pick;
    logic [1:0] exp_rdy;
    exp_t       e;
    int         k;
    @(negedge clk);
    req_valid = v;
    req_a0 = a0; req_b0 = b0; req_instr0 = i0;
    req_a1 = a1; req_b1 = b1; req_instr1 = i1;
    rsp_ready = rr;
    #1;
    k    = cyc;
    idle = !m_pending && (k >= m_idle_from);
    pick = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : ~m_last;
    exp_rdy = idle ? (pick ? 2'b10 : 2'b01) : 2'b00;
    if (v != 2'b00) check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    else check("req_ready_idle", {31'd0, ($countones(req_ready) <= 1) && (idle || req_ready == 2'b00)}, 32'd1);
    check("busy", {31'd0, busy}, {31'd0, !idle});
    check("alu_ports", {20'd0, alu_a, alu_b, alu_instr}, {20'd0, m_a, m_b, m_i});
    if (idle && v[pick]) begin
      m_a = pick ? a1 : a0;
      m_b = pick ? b1 : b0;
      m_i = pick ? i1 : i0;
      e.id    = pick;
      e.data  = alu_fn(m_a, m_b, m_i);
      e.start = k + LAT + 1;
      sb_q.push_back(e);
      m_last       = pick;
      m_id         = pick;
      m_pending    = 1'b1;
      m_resp_start = k + LAT + 1;
    end else if (m_pending && k >= m_resp_start && rr[m_id]) begin
      m_pending   = 1'b0;
      m_idle_from = k + 1;
    end
  endtask

  task automatic idle_cycle(input logic [1:0] rr);
    drive(2'b00, '0, '0, '0, '0, '0, '0, rr);
  endtask

  task automatic reset_outputs_zero();
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  {28'd0, rsp_data}, 32'd0);
    check("rst_alu",       {20'd0, alu_a, alu_b, alu_instr}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_busy_3",    {31'd0, busy_3}, 32'd0);
  endtask

  // Monitor: whenever a response is presented, it must match the oldest expected one.
  initial begin
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      #3;
      k = cyc;
      if (rsp_valid != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
        end else begin
          e = sb_q[0];
          check("rsp_valid", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
          check("rsp_data", {28'd0, rsp_data}, {28'd0, e.data});
          if (k < e.start) check("rsp_early", k, e.start);
          if (rsp_ready[e.id]) void'(sb_q.pop_front());
        end
      end else if (sb_q.size() != 0 && sb_q[0].start == k) begin
        check("rsp_missing", {30'd0, rsp_valid}, sb_q[0].id ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_instr0 = '0; req_instr1 = '0;
    req_valid_3 = '0; rsp_ready_3 = '0; alu_result_3 = '0;
    req_a0_3 = '0; req_b0_3 = '0; req_a1_3 = '0; req_b1_3 = '0; req_instr0_3 = '0; req_instr1_3 = '0;
    model_reset();

    @(negedge clk);
    #1;
    reset_outputs_zero();
    @(negedge clk);
    #4 rst_n = 1'b1;

    // Tie after reset: 0, then 1, then 0 again.
    repeat (7) drive(2'b11, 4'd3, 4'd5, 4'b0001, 4'd7, 4'd2, 4'b0010, 2'b11);
    repeat (3) idle_cycle(2'b11);

    // Single op on requester 0.
    drive(2'b01, 4'd3, 4'd5, 4'b0001, '0, '0, '0, 2'b00);
    idle_cycle(2'b00);
    check("single_alu_instr", {28'd0, alu_instr}, 32'h1);
    idle_cycle(2'b00);
    check("single_rsp_valid", {30'd0, rsp_valid}, 32'h1);
    check("single_rsp_data", {28'd0, rsp_data}, 32'h8);
    idle_cycle(2'b01);
    idle_cycle(2'b00);

    // Wrong-requester rsp_ready pulses, then backpressure with both requesting.
    drive(2'b01, 4'd9, 4'd4, 4'b0010, '0, '0, '0, 2'b10);
    idle_cycle(2'b10);
    idle_cycle(2'b10);
    repeat (5) begin
      drive(2'b11, 4'd1, 4'd1, 4'b0001, 4'd2, 4'd2, 4'b0001, 2'b00);
      check("bp_rsp_valid", {30'd0, rsp_valid}, 32'h1);
      check("bp_rsp_data", {28'd0, rsp_data}, 32'd13);
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    idle_cycle(2'b01);
    idle_cycle(2'b00);

    // Reset while in EXEC: operation dropped, next tie goes to requester 0.
    drive(2'b10, '0, '0, '0, 4'd6, 4'd6, 4'b0001, 2'b11);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    reset_outputs_zero();
    model_reset();
    req_valid = '0; rsp_ready = '0;
    @(negedge clk);
    #4 rst_n = 1'b1;
    repeat (4) idle_cycle(2'b11);
    drive(2'b11, 4'd4, 4'd4, 4'b0011, 4'd5, 4'd5, 4'b0011, 2'b11);
    check("post_reset_tie", {30'd0, req_ready}, 32'h1);
    repeat (3) idle_cycle(2'b11);

    // Randomized traffic.
    repeat (400) begin
      drive(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
    end

    // Drain with a bounded budget.
    for (int i = 0; i < 20 && (sb_q.size() != 0 || m_pending); i++) idle_cycle(2'b11);
    check("drain_empty", sb_q.size(), 32'd0);

    // LAT=3 instance: result sampled three cycles after accept, held after alu_result moves.
    @(negedge clk);
    req_valid_3 = 2'b10; req_a1_3 = 4'd5; req_b1_3 = 4'd2; req_instr1_3 = 4'b1000; alu_result_3 = 4'd1;
    #1 check("l3_req_ready", {30'd0, req_ready_3}, 32'h2);
    @(negedge clk);
    req_valid_3 = 2'b00; alu_result_3 = 4'd3;
    #1;
    check("l3_t1_rsp_valid", {30'd0, rsp_valid_3}, 32'd0);
    check("l3_t1_busy", {31'd0, busy_3}, 32'd1);
    check("l3_alu_ports", {20'd0, alu_a_3, alu_b_3, alu_instr_3}, {20'd0, 4'd5, 4'd2, 4'b1000});
    @(negedge clk);
    alu_result_3 = 4'd4;
    #1 check("l3_t2_rsp_valid", {30'd0, rsp_valid_3}, 32'd0);
    @(negedge clk);
    alu_result_3 = 4'd11;
    #1 check("l3_t3_rsp_valid", {30'd0, rsp_valid_3}, 32'd0);
    @(negedge clk);
    alu_result_3 = 4'd15; rsp_ready_3 = 2'b01;
    #1;
    check("l3_t4_rsp_valid", {30'd0, rsp_valid_3}, 32'h2);
    check("l3_t4_rsp_data", {28'd0, rsp_data_3}, 32'd11);
    @(negedge clk);
    alu_result_3 = 4'd0; rsp_ready_3 = 2'b10;
    #1;
    check("l3_t5_rsp_valid", {30'd0, rsp_valid_3}, 32'h2);
    check("l3_t5_rsp_data", {28'd0, rsp_data_3}, 32'd11);
    @(negedge clk);
    rsp_ready_3 = 2'b00;
    #1;
    check("l3_done_busy", {31'd0, busy_3}, 32'd0);
    check("l3_done_rsp_valid", {30'd0, rsp_valid_3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
